dp_ctrl_unit: RTL and testbench
===============================

DP_CTRL_UNIT -- requirements
Module: dp_ctrl_unit

Interface
REQ-001 The block SHALL have parameter ALUCTRL_W, default 3, meaning ALU control width (values below 3 are illegal).
REQ-002 The block SHALL have parameter ERRCNT_W, default 8, meaning illegal-op counter width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-004 The block SHALL have the following decode-side ports:
- in_valid input 1: instruction offered.
- in_ready output 1: block accepts instruction.
- alu_op input 1: data-processing instruction.
- funct input 6: funct[4:1] is cmd, funct[0] is S bit.
- cond input 4: ARM condition field.
REQ-005 The block SHALL have the following output-side ports:
- out_valid output 1: decoded word held.
- out_ready input 1: consumer takes word.
- alu_control output ALUCTRL_W: ALU operation.
- flag_write output 2: [1] NZ write enable, [0] CV write enable, already gated by cond_ex.
- no_write output 1: suppress register write.
- cond_ex output 1: condition passed.
- illegal output 1: unsupported cmd.
REQ-006 The block SHALL have the following flag and counter ports:
- alu_flags input 4: {N,Z,C,V} from execute.
- flags_en input 1: alu_flags valid for the held instruction.
- flags output 4: architectural NZCV register.
- err_cnt output ERRCNT_W: illegal-op count.

Function
REQ-007 The block SHALL be a one-entry decode register: in_ready = !out_valid | out_ready, an instruction loads on in_valid & in_ready, and the decoded word appears on the next cycle (latency 1).
REQ-008 While out_valid=1 and out_ready=0, all decoded outputs SHALL hold stable.
REQ-009 When alu_op=1, cmd SHALL map to alu_control and decode flags as follows:
- 0100 ADD gives 0.
- 0010 SUB gives 1.
- 0000 AND gives 2.
- 1100 ORR gives 3.
- 0001 EOR gives 4.
- 1101 MOV gives 5.
- 1010 CMP gives 1, with no_write=1 and FlagW=11 regardless of S.
- 1011 CMN gives 0, with no_write=1 and FlagW=11 regardless of S.
- 1000 TST gives 2, with no_write=1 and FlagW=10 regardless of S.
REQ-010 For non-compare ops, decode FlagW[1] SHALL equal S and FlagW[0] SHALL equal S & (ADD|SUB); no_write SHALL be 0.
REQ-011 When alu_op=1 and cmd is unsupported, the block SHALL drive alu_control=0, FlagW=00, no_write=1 and illegal=1.
REQ-012 When alu_op=0, the block SHALL drive alu_control=0 (ADD), FlagW=00, no_write=0 and illegal=0.
REQ-013 cond_ex SHALL be evaluated at load time against the flags value defined in REQ-017, for EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL (1110); cond=1111 SHALL give cond_ex=0.
REQ-014 flag_write SHALL equal FlagW & {2{cond_ex}}; no_write SHALL be forced to 1 when cond_ex=0.
REQ-015 When flags_en=1 and out_valid=1, the flags register SHALL update N,Z from alu_flags[3:2] if flag_write[1]=1, and C,V from alu_flags[1:0] if flag_write[0]=1.
REQ-016 When flags_en=1 and out_valid=0, the block SHALL ignore flags_en.
REQ-017 When flags_en and a load occur in the same cycle, the new instruction's cond_ex SHALL use the post-update flags (bypass).
REQ-018 err_cnt SHALL increment by one per accepted illegal instruction and saturate at all-ones.

Reset
REQ-019 While reset_n=0, the block SHALL asynchronously clear out_valid, alu_control, flag_write, no_write, cond_ex, illegal, flags and err_cnt; in_ready SHALL be 1 during reset.
REQ-020 On reset mid-transfer, the block SHALL discard the held word, and no flag update SHALL occur.

Structure
REQ-021 A shared package SHALL hold the cmd encodings, the alu_control op enumeration, the condition-code enumeration and the NZCV bit indices.
REQ-022 Condition evaluation SHALL be a separate combinational sub-module named cond_check (inputs cond, flags; output cond_ex).

Verification
REQ-023 The bench SHALL load ADD with S=1 (funct=6'b001001, cond=1110) -> after 1 cycle alu_control=0, flag_write=11, no_write=0, cond_ex=1.
REQ-024 The bench SHALL load CMP (funct=6'b010100, S=0) -> alu_control=1, flag_write=11, no_write=1; with flags_en=1 and alu_flags=0100 -> flags=0100.
REQ-025 The bench SHALL apply flags_en with alu_flags=0100 and, in the same cycle, load SUB with cond=0000 (EQ) -> cond_ex=1 via bypass.
REQ-026 The bench SHALL hold out_ready=0 with out_valid=1 and offer a new instruction -> in_ready=0, outputs unchanged; on raising out_ready, the new word appears the next cycle.
REQ-027 The bench SHALL load 2^ERRCNT_W+2 illegal cmds (cmd=0111) -> illegal=1, no_write=1, err_cnt saturates at 8'hFF.
REQ-028 The bench SHALL assert reset_n=0 mid-hold, asynchronously -> out_valid=0, flags=0000 and err_cnt=0 immediately.

Source files
------------

// File: rtl/dp_ctrl_unit_pkg.sv
// Shared definitions for the data-processing decode/control unit: command encodings,
// ALU op and condition enumerations, NZCV bit positions and the decode helper.
package dp_ctrl_unit_pkg;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdTst = 4'b1000;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdCmn = 4'b1011;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdMov = 4'b1101;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOrr = 3'd3,
    AluEor = 3'd4,
    AluMov = 3'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  typedef struct packed {
    alu_op_e    alu;
    logic [1:0] flag_w;
    logic       no_write;
    logic       illegal;
  } dec_t;

  // Ungated decode; the condition result is applied by the caller.
  function automatic dec_t decode(input logic alu_op, input logic [3:0] cmd, input logic s);
    dec_t d;
    d.alu      = AluAdd;
    d.flag_w   = 2'b00;
    d.no_write = 1'b0;
    d.illegal  = 1'b0;
    if (alu_op) begin
      case (cmd)
        CmdAdd: begin d.alu = AluAdd; d.flag_w = {s, s};    end
        CmdSub: begin d.alu = AluSub; d.flag_w = {s, s};    end
        CmdAnd: begin d.alu = AluAnd; d.flag_w = {s, 1'b0}; end
        CmdOrr: begin d.alu = AluOrr; d.flag_w = {s, 1'b0}; end
        CmdEor: begin d.alu = AluEor; d.flag_w = {s, 1'b0}; end
        CmdMov: begin d.alu = AluMov; d.flag_w = {s, 1'b0}; end
        CmdCmp: begin d.alu = AluSub; d.flag_w = 2'b11; d.no_write = 1'b1; end
        CmdCmn: begin d.alu = AluAdd; d.flag_w = 2'b11; d.no_write = 1'b1; end
        CmdTst: begin d.alu = AluAnd; d.flag_w = 2'b10; d.no_write = 1'b1; end
        default: begin d.no_write = 1'b1; d.illegal = 1'b1; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/dp_ctrl_unit_if.sv
// Decode-side and output-side handshake bundle of the decode/control unit.
interface dp_ctrl_unit_if #(
  parameter int unsigned ALUCTRL_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 alu_op;
  logic [5:0]           funct;
  logic [3:0]           cond;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [1:0]           flag_write;
  logic                 no_write;
  logic                 cond_ex;
  logic                 illegal;

  modport master (
    output in_valid, alu_op, funct, cond, out_ready,
    input  in_ready, out_valid, alu_control, flag_write, no_write, cond_ex, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, cond, out_ready,
    output in_ready, out_valid, alu_control, flag_write, no_write, cond_ex, illegal
  );
endinterface

// File: rtl/dp_ctrl_unit_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV value.
module cond_check
  import dp_ctrl_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;

  always_comb begin
    n = flags[FlagN];
    z = flags[FlagZ];
    c = flags[FlagC];
    v = flags[FlagV];
    cond_ex = 1'b0;
    case (cond_e'(cond))
      CondEq: cond_ex = z;
      CondNe: cond_ex = ~z;
      CondCs: cond_ex = c;
      CondCc: cond_ex = ~c;
      CondMi: cond_ex = n;
      CondPl: cond_ex = ~n;
      CondVs: cond_ex = v;
      CondVc: cond_ex = ~v;
      CondHi: cond_ex = c & ~z;
      CondLs: cond_ex = ~c | z;
      CondGe: cond_ex = (n == v);
      CondLt: cond_ex = (n != v);
      CondGt: cond_ex = ~z & (n == v);
      CondLe: cond_ex = z | (n != v);
      CondAl: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_ctrl_unit.sv
// One-entry decode register for data-processing instructions with condition evaluation,
// architectural NZCV register and a saturating illegal-op counter.
module dp_ctrl_unit
  import dp_ctrl_unit_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  dp_ctrl_unit_if.slave       bus,
  input  logic [3:0]          alu_flags,
  input  logic                flags_en,
  output logic [3:0]          flags,
  output logic [ERRCNT_W-1:0] err_cnt
);
  logic                 out_valid_q, out_valid_d;
  logic [ALUCTRL_W-1:0] alu_control_q, alu_control_d;
  logic [1:0]           flag_write_q, flag_write_d;
  logic                 no_write_q, no_write_d;
  logic                 cond_ex_q, cond_ex_d;
  logic                 illegal_q, illegal_d;
  logic [3:0]           flags_q, flags_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic in_ready, load, cond_ex_new;
  dec_t dec;
  logic unused_funct;

  assign unused_funct = bus.funct[5];
  assign in_ready     = ~out_valid_q | bus.out_ready;
  assign load         = bus.in_valid & in_ready;
  assign dec          = decode(bus.alu_op, bus.funct[4:1], bus.funct[0]);

  // Post-update flags; also feeds the condition check so a same-cycle load sees them.
  always_comb begin
    flags_d = flags_q;
    if (flags_en && out_valid_q) begin
      if (flag_write_q[1]) begin
        flags_d[FlagN] = alu_flags[FlagN];
        flags_d[FlagZ] = alu_flags[FlagZ];
      end
      if (flag_write_q[0]) begin
        flags_d[FlagC] = alu_flags[FlagC];
        flags_d[FlagV] = alu_flags[FlagV];
      end
    end
  end

  cond_check u_cond_check (
    .cond    (bus.cond),
    .flags   (flags_d),
    .cond_ex (cond_ex_new)
  );

  always_comb begin
    out_valid_d   = out_valid_q;
    alu_control_d = alu_control_q;
    flag_write_d  = flag_write_q;
    no_write_d    = no_write_q;
    cond_ex_d     = cond_ex_q;
    illegal_d     = illegal_q;
    err_cnt_d     = err_cnt_q;
    if (load) begin
      out_valid_d   = 1'b1;
      alu_control_d = ALUCTRL_W'(dec.alu);
      flag_write_d  = dec.flag_w & {2{cond_ex_new}};
      no_write_d    = dec.no_write | ~cond_ex_new;
      cond_ex_d     = cond_ex_new;
      illegal_d     = dec.illegal;
      if (dec.illegal && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      alu_control_q <= '0;
      flag_write_q  <= 2'b00;
      no_write_q    <= 1'b0;
      cond_ex_q     <= 1'b0;
      illegal_q     <= 1'b0;
      flags_q       <= 4'b0000;
      err_cnt_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_control_q <= alu_control_d;
      flag_write_q  <= flag_write_d;
      no_write_q    <= no_write_d;
      cond_ex_q     <= cond_ex_d;
      illegal_q     <= illegal_d;
      flags_q       <= flags_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_control = alu_control_q;
  assign bus.flag_write  = flag_write_q;
  assign bus.no_write    = no_write_q;
  assign bus.cond_ex     = cond_ex_q;
  assign bus.illegal     = illegal_q;
  assign flags           = flags_q;
  assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_dp_ctrl_unit.sv
// Directed self-checking bench for dp_ctrl_unit.
module tb_dp_ctrl_unit;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned ERRCNT_W  = 8;

  logic                clk;
  logic                reset_n;
  logic [3:0]          alu_flags;
  logic                flags_en;
  logic [3:0]          flags;
  logic [ERRCNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  dp_ctrl_unit_if #(.ALUCTRL_W(ALUCTRL_W)) bus ();

  dp_ctrl_unit #(
    .ALUCTRL_W (ALUCTRL_W),
    .ERRCNT_W  (ERRCNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .alu_flags (alu_flags),
    .flags_en  (flags_en),
    .flags     (flags),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic op, input logic [5:0] f, input logic [3:0] c);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = f;
    bus.cond     = c;
  endtask

  task automatic chk_word(input string tag, input logic [2:0] alu, input logic [1:0] fw,
                          input logic nw, input logic ce, input logic il);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".alu"}, 32'(bus.alu_control), 32'(alu));
    chk({tag, ".fw"}, 32'(bus.flag_write), 32'(fw));
    chk({tag, ".nw"}, 32'(bus.no_write), 32'(nw));
    chk({tag, ".cex"}, 32'(bus.cond_ex), 32'(ce));
    chk({tag, ".ill"}, 32'(bus.illegal), 32'(il));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 1'b0;
    bus.funct     = 6'b0;
    bus.cond      = 4'b1110;
    bus.out_ready = 1'b1;
    alu_flags     = 4'b0;
    flags_en      = 1'b0;
    #12;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.err", 32'(err_cnt), 32'd0);
    chk("rst.alu", 32'(bus.alu_control), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // ADD S=1, always
    offer(1'b1, 6'b001001, 4'b1110);
    step();
    bus.in_valid = 1'b0;
    chk_word("add", 3'd0, 2'b11, 1'b0, 1'b1, 1'b0);

    // CMP S=0 then flag update from execute
    offer(1'b1, 6'b010100, 4'b1110);
    step();
    bus.in_valid = 1'b0;
    chk_word("cmp", 3'd1, 2'b11, 1'b1, 1'b1, 1'b0);
    flags_en  = 1'b1;
    alu_flags = 4'b0100;
    step();
    flags_en = 1'b0;
    chk("cmp.flags", 32'(flags), 32'h4);
    chk("cmp.drained", 32'(bus.out_valid), 32'd0);

    // flags_en with nothing held is ignored
    flags_en  = 1'b1;
    alu_flags = 4'b1111;
    step();
    flags_en = 1'b0;
    chk("idle.flags_en", 32'(flags), 32'h4);

    // Clear Z via a CMP so the bypass case is observable
    offer(1'b1, 6'b010100, 4'b1110);
    step();
    bus.in_valid = 1'b0;
    flags_en  = 1'b1;
    alu_flags = 4'b0000;
    step();
    flags_en = 1'b0;
    chk("clr.flags", 32'(flags), 32'h0);

    // Bypass: update Z=1 and load SUB EQ in the same cycle
    offer(1'b1, 6'b010100, 4'b1110);
    step();
    flags_en  = 1'b1;
    alu_flags = 4'b0100;
    offer(1'b1, 6'b000101, 4'b0000);
    step();
    flags_en     = 1'b0;
    bus.in_valid = 1'b0;
    chk_word("byp", 3'd1, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("byp.flags", 32'(flags), 32'h4);

    // More decodes with flags = 0100 (Z set)
    offer(1'b1, 6'b011000, 4'b1110);  // ORR S=0
    step();
    chk_word("orr", 3'd3, 2'b00, 1'b0, 1'b1, 1'b0);
    offer(1'b1, 6'b010000, 4'b1110);  // TST
    step();
    chk_word("tst", 3'd2, 2'b10, 1'b1, 1'b1, 1'b0);
    offer(1'b1, 6'b011011, 4'b0001);  // MOV S=1, NE fails
    step();
    chk_word("mov.ne", 3'd5, 2'b00, 1'b1, 1'b0, 1'b0);
    offer(1'b1, 6'b000010, 4'b1111);  // EOR, cond 1111
    step();
    chk_word("eor.nv", 3'd4, 2'b00, 1'b1, 1'b0, 1'b0);
    offer(1'b1, 6'b000001, 4'b0010);  // AND S=1, CS fails (C=0)
    step();
    chk_word("and.cs", 3'd2, 2'b00, 1'b1, 1'b0, 1'b0);
    offer(1'b1, 6'b010111, 4'b1101);  // CMN, LE passes (Z=1)
    step();
    chk_word("cmn.le", 3'd0, 2'b11, 1'b1, 1'b1, 1'b0);
    offer(1'b0, 6'b011011, 4'b1110);  // non-ALU
    step();
    bus.in_valid = 1'b0;
    chk_word("nonalu", 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Backpressure hold
    step();
    bus.out_ready = 1'b0;
    offer(1'b1, 6'b011000, 4'b1110);  // ORR
    step();
    chk_word("hold.ld", 3'd3, 2'b00, 1'b0, 1'b1, 1'b0);
    offer(1'b1, 6'b010000, 4'b1110);  // TST offered while stalled
    #1;
    chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk_word("hold.1", 3'd3, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    chk_word("hold.2", 3'd3, 2'b00, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("hold.release", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk_word("hold.new", 3'd2, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("hold.err", 32'(err_cnt), 32'd0);

    // Illegal ops and counter saturation
    offer(1'b1, 6'b001110, 4'b1110);
    step();
    chk_word("ill.1", 3'd0, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("ill.cnt1", 32'(err_cnt), 32'd1);
    for (int i = 1; i < 254; i++) step();
    chk("ill.cnt254", 32'(err_cnt), 32'd254);
    for (int i = 254; i < (1 << ERRCNT_W) + 2; i++) step();
    bus.in_valid = 1'b0;
    chk("ill.sat", 32'(err_cnt), 32'hFF);
    chk("ill.flag", 32'(bus.illegal), 32'd1);

    // Asynchronous reset mid-hold
    bus.out_ready = 1'b0;
    offer(1'b1, 6'b001001, 4'b1110);
    step();
    bus.in_valid = 1'b0;
    chk("pre.valid", 32'(bus.out_valid), 32'd1);
    flags_en  = 1'b1;
    alu_flags = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.out_valid), 32'd0);
    chk("arst.flags", 32'(flags), 32'd0);
    chk("arst.err", 32'(err_cnt), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst.fw", 32'(bus.flag_write), 32'd0);
    step();
    chk("arst.hold_flags", 32'(flags), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
